i2c_cfg_arbiter: RTL and testbench
==================================

// Module: i2c_cfg_arbiter
// PURPOSE
//  Owns the single i2cgenerator instance in the codec path and decides what gets written to it.
//  After reset it plays a fixed codec init table: 0F<-000, 06<-00E, 04<-00A, 09<-001.
//  It then shares the generator between NREQ requesters (e.g. key-driven mode FSMs) in round-robin order.
//  It drives the generator's load/data pair, waits out each transfer and flags a hung transfer by timeout.
// PARAMETERS
//  NREQ        2      number of requester ports (1..8)
//  INIT_LEN    4      entries in the internal init table (indices 0..INIT_LEN-1)
//  TIMEOUT     65535  max clk cycles in WAIT before abort (16-bit counter)
// PORTS
//  clk        in   1         system clock
//  reset      in   1         synchronous, active-high reset
//  gen_ready  in   1         i2cgenerator ready: idle, may accept load
//  gen_load   out  1         one-cycle load strobe to i2cgenerator
//  gen_data   out  16        {reg_addr[6:0], reg_val[8:0]} to i2cgenerator
//  req        in   NREQ      level request per requester, held until ack
//  req_data   in   16*NREQ   packed words; requester i uses [16*i+15:16*i]
//  ack        out  NREQ      one-cycle pulse: requester i's word was loaded
//  init_done  out  1         init table fully written; sticky until reset
//  busy       out  1         high in every state except IDLE
//  timeout    out  1         sticky: some transfer exceeded TIMEOUT; cleared by reset
// BEHAVIOUR
//  Reset (sync, 1 cycle) gives these values:
//   - state=INIT, init index=0, rr pointer=0
//   - gen_load=0, gen_data=0, ack=0, init_done=0, busy=1, timeout=0
//  States:
//   - INIT: if gen_ready, gen_load=1, gen_data=table[idx] -> HOLD.
//   - HOLD: exactly 1 cycle; gen_ready is ignored because the generator drops it the cycle after load -> WAIT.
//   - WAIT: timer counts from 0. Exits:
//     - gen_ready=1: if the transfer was init and idx<INIT_LEN-1, idx++ -> INIT.
//       If it was init and idx=INIT_LEN-1, init_done<=1 -> IDLE. Otherwise -> IDLE.
//     - timer reaches TIMEOUT: timeout<=1, abort the transfer -> IDLE. During init, init_done is also set so
//       requesters are not starved.
//   - IDLE: busy=0. If gen_ready and |req, pick the first set req at or after the rr pointer (wrapping NREQ-1->0).
//     Then gen_load=1, gen_data=req_data[winner], ack[winner]=1, rr pointer<=winner+1 mod NREQ -> HOLD.
//  Output timing:
//   - gen_load and ack are registered and assert in the same cycle, one cycle after the decision.
//   - gen_data is registered; it changes only with gen_load and holds through HOLD/WAIT.
//  Rules:
//   - req is ignored until init_done=1. Requests raised during init wait; they are never dropped.
//   - At most one gen_load per transfer; no load while busy=1 except the INIT/IDLE issue cycle.
//   - If gen_ready=0 in IDLE, arbitration stalls and the rr pointer is unchanged.
//   - A req deasserted before ack is simply not granted; no partial state is kept.
//   - The rr pointer advances only on a grant.
//   - Reset asserted mid-transfer returns to INIT idx 0 next cycle. The generator shares this reset, so
//     the table replays from the first entry.
//   - The timeout counter saturates; it does not wrap.
// TESTING
//  1. Release reset with a generator model (ready drops 1 cycle after load, returns after 40 cycles)
//     -> 4 loads carrying 1E00, 0C0E, 080A, 1201, then init_done=1 and busy=0.
//  2. Hold req=2'b01 from cycle 0 with data 0C9F -> no ack before init_done. After init, one ack[0] pulse
//     and gen_data=0C9F.
//  3. Assert req=2'b11 continuously -> grants alternate ack[0], ack[1], ack[0]... with exactly one load
//     per completed transfer.
//  4. Hold gen_ready=0 after a load for TIMEOUT+5 cycles -> timeout=1 at cycle TIMEOUT, state IDLE, no
//     extra load; timeout stays 1 until reset.
//  5. Assert reset during WAIT of init entry 2 -> next cycle gen_load=0 and init_done=0. The table
//     restarts with 1E00.
//  6. Set NREQ=4 and req=4'b1001 with rr pointer=1 -> ack[3] first, then ack[0].

Source files
------------

// File: rtl/i2c_cfg_arbiter.sv
// Codec config arbiter: replays a fixed init table into the i2c generator,
// then shares it round-robin between NREQ requesters with a hung-transfer timeout.
module i2c_cfg_arbiter #(
  parameter int NREQ     = 2,
  parameter int INIT_LEN = 4,
  parameter int TIMEOUT  = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gen_ready,
  output logic                 gen_load,
  output logic [15:0]          gen_data,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic                 init_done,
  output logic                 busy,
  output logic                 timeout
);
  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam logic [15:0]   TMAX      = 16'(TIMEOUT);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_LEN - 1);

  typedef enum logic [1:0] {S_INIT, S_HOLD, S_WAIT, S_IDLE} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  init_idx;
  logic [RW-1:0]  rr_ptr, rr_nxt, grant_idx;
  logic           grant_vld;
  logic [15:0]    timer;
  logic           load_nxt;
  logic [15:0]    data_nxt;
  logic [NREQ-1:0] ack_nxt, req_eff;

  // Entries are {reg_addr[6:0], reg_val[8:0]}.
  function automatic logic [15:0] init_word(input logic [IW-1:0] i);
    case (int'(i))
      0:       init_word = {7'h0F, 9'h000};
      1:       init_word = {7'h06, 9'h00E};
      2:       init_word = {7'h04, 9'h00A};
      3:       init_word = {7'h09, 9'h001};
      default: init_word = 16'h0000;
    endcase
  endfunction

  assign busy    = (state != S_IDLE);
  assign req_eff = init_done ? req : '0;

  // Round-robin search starting at rr_ptr, wrapping NREQ-1 -> 0.
  always_comb begin
    int j;
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_nxt    = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!grant_vld && req_eff[j]) begin
        grant_vld = 1'b1;
        grant_idx = RW'(j);
      end
    end
    j = int'(grant_idx) + 1;
    if (j >= NREQ) j = 0;
    rr_nxt = RW'(j);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: if (gen_ready) state_nxt = S_HOLD;
      S_HOLD: state_nxt = S_WAIT;
      S_WAIT: begin
        if (gen_ready)
          state_nxt = (!init_done && init_idx != INIT_LAST) ? S_INIT : S_IDLE;
        else if (timer == TMAX)
          state_nxt = S_IDLE;
      end
      S_IDLE: if (gen_ready && grant_vld) state_nxt = S_HOLD;
      default: state_nxt = S_INIT;
    endcase
  end

  // Next values for the registered load/data/ack outputs.
  always_comb begin
    load_nxt = 1'b0;
    data_nxt = gen_data;
    ack_nxt  = '0;
    if (state == S_INIT && gen_ready) begin
      load_nxt = 1'b1;
      data_nxt = init_word(init_idx);
    end else if (state == S_IDLE && gen_ready && grant_vld) begin
      load_nxt           = 1'b1;
      data_nxt           = req_data[int'(grant_idx)*16 +: 16];
      ack_nxt[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      init_idx  <= '0;
      rr_ptr    <= '0;
      timer     <= '0;
      init_done <= 1'b0;
      timeout   <= 1'b0;
      gen_load  <= 1'b0;
      gen_data  <= '0;
      ack       <= '0;
    end else begin
      gen_load <= load_nxt;
      gen_data <= data_nxt;
      ack      <= ack_nxt;
      if (state == S_HOLD)
        timer <= '0;
      else if (state == S_WAIT && timer != 16'hFFFF)
        timer <= timer + 16'd1;
      if (state == S_WAIT) begin
        if (gen_ready) begin
          if (!init_done) begin
            if (init_idx == INIT_LAST) init_done <= 1'b1;
            else                       init_idx  <= init_idx + 1'b1;
          end
        end else if (timer == TMAX) begin
          // An aborted init still releases the requesters.
          timeout   <= 1'b1;
          init_done <= 1'b1;
        end
      end
      if (state == S_IDLE && gen_ready && grant_vld)
        rr_ptr <= rr_nxt;
    end
  end
endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// Bench for i2c_cfg_arbiter: generator models, load scoreboard and scenario tasks.
module tb_i2c_cfg_arbiter;
  localparam int T1  = 100;
  localparam int LAT = 40;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  ack;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        hang;
  logic        gen_ready1, gen_load1, init_done1, busy1, timeout1;
  logic [15:0] gen_data1;
  logic [1:0]  req1, ack1;
  logic [31:0] req_data1;
  logic        gen_ready4, gen_load4, init_done4, busy4, timeout4;
  logic [15:0] gen_data4;
  logic [3:0]  req4, ack4;
  logic [63:0] req_data4;
  logic [7:0]  cnt1, cnt4;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  i2c_cfg_arbiter #(.NREQ(2), .INIT_LEN(4), .TIMEOUT(T1)) u1 (
    .clk(clk), .reset(reset), .gen_ready(gen_ready1), .gen_load(gen_load1),
    .gen_data(gen_data1), .req(req1), .req_data(req_data1), .ack(ack1),
    .init_done(init_done1), .busy(busy1), .timeout(timeout1));

  i2c_cfg_arbiter #(.NREQ(4), .INIT_LEN(4), .TIMEOUT(1000)) u4 (
    .clk(clk), .reset(reset), .gen_ready(gen_ready4), .gen_load(gen_load4),
    .gen_data(gen_data4), .req(req4), .req_data(req_data4), .ack(ack4),
    .init_done(init_done4), .busy(busy4), .timeout(timeout4));

  // Generator: ready drops the cycle after a load, returns LAT cycles later.
  assign gen_ready1 = (cnt1 == 8'd0) && !hang;
  assign gen_ready4 = (cnt4 == 8'd0);
  always @(posedge clk) begin
    if (reset)                 cnt1 <= 8'd0;
    else if (gen_load1)        cnt1 <= 8'(LAT);
    else if (cnt1 != 8'd0)     cnt1 <= cnt1 - 8'd1;
  end
  always @(posedge clk) begin
    if (reset)                 cnt4 <= 8'd0;
    else if (gen_load4)        cnt4 <= 8'(LAT);
    else if (cnt4 != 8'd0)     cnt4 <= cnt4 - 8'd1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (gen_load1 === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load got data=%h ack=%b want no load", gen_data1, ack1);
        end else begin
          mon_e = exp_q.pop_front();
          if (gen_data1 !== mon_e.data || ack1 !== mon_e.ack) begin
            errors++;
            $display("FAIL load_word got data=%h ack=%b want data=%h ack=%b",
                     gen_data1, ack1, mon_e.data, mon_e.ack);
          end
        end
      end else if (ack1 !== 2'b00) begin
        checks++;
        errors++;
        $display("FAIL ack_without_load got ack=%b want 00", ack1);
      end
    end
  end

  task automatic push(input logic [15:0] d, input logic [1:0] a);
    exp_t e;
    e.data = d;
    e.ack  = a;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    push(16'h1E00, 2'b00);
    push(16'h0C0E, 2'b00);
    push(16'h080A, 2'b00);
    push(16'h1201, 2'b00);
  endtask

  task automatic test_reset();
    reset = 1'b1; hang = 1'b0;
    req1 = '0; req_data1 = '0; req4 = '0; req_data4 = '0;
    repeat (3) @(negedge clk);
    checks++; if (gen_load1 !== 1'b0)     begin errors++; $display("FAIL reset_gen_load got=%b want=0", gen_load1); end
    checks++; if (gen_data1 !== 16'h0000) begin errors++; $display("FAIL reset_gen_data got=%h want=0000", gen_data1); end
    checks++; if (ack1 !== 2'b00)         begin errors++; $display("FAIL reset_ack got=%b want=00", ack1); end
    checks++; if (init_done1 !== 1'b0)    begin errors++; $display("FAIL reset_init_done got=%b want=0", init_done1); end
    checks++; if (busy1 !== 1'b1)         begin errors++; $display("FAIL reset_busy got=%b want=1", busy1); end
    checks++; if (timeout1 !== 1'b0)      begin errors++; $display("FAIL reset_timeout got=%b want=0", timeout1); end
  endtask

  task automatic test_init();
    bit got = 0, early = 0;
    push_init();
    req1 = 2'b01;
    req_data1 = {16'h0000, 16'h0C9F};
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ack1 !== 2'b00 && init_done1 !== 1'b1) early = 1;
      if (init_done1 === 1'b1) begin got = 1; break; end
    end
    checks++; if (!got)  begin errors++; $display("FAIL init_done_wait got=0 want=1 within 400 cycles"); end
    checks++; if (early) begin errors++; $display("FAIL ack_during_init got=1 want=0"); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL init_end_busy got=%b want=0", busy1); end
    checks++; if (gen_data1 !== 16'h1201) begin errors++; $display("FAIL init_last_data got=%h want=1201", gen_data1); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL init_loads_left got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_req_hold();
    bit got = 0;
    push(16'h0C9F, 2'b01);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack1 !== 2'b00) begin got = 1; break; end
    end
    checks++; if (!got || ack1 !== 2'b01) begin errors++; $display("FAIL held_req_ack got=%b want=01", ack1); end
    checks++; if (gen_data1 !== 16'h0C9F) begin errors++; $display("FAIL held_req_data got=%h want=0C9F", gen_data1); end
    req1 = 2'b00;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy1 === 1'b0) begin got = 1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL held_req_idle got busy=%b want 0", busy1); end
  endtask

  task automatic test_alternate();
    bit got = 0;
    req_data1 = {16'h2222, 16'h1111};
    push(16'h2222, 2'b10);
    push(16'h1111, 2'b01);
    push(16'h2222, 2'b10);
    push(16'h1111, 2'b01);
    req1 = 2'b11;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin got = 1; break; end
    end
    req1 = 2'b00;
    checks++; if (!got) begin errors++; $display("FAIL alternate_grants got left=%0d want=0", exp_q.size()); end
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy1 === 1'b0) begin got = 1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL alternate_idle got busy=%b want 0", busy1); end
    repeat (50) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit got = 0;
    int n = 0;
    req_data1 = {16'h0000, 16'h0ABC};
    push(16'h0ABC, 2'b01);
    req1 = 2'b01;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gen_load1 === 1'b1) begin got = 1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL timeout_load got=0 want=1"); end
    hang = 1'b1;
    req1 = 2'b00;
    // One HOLD cycle plus WAIT with timer 0..T1 before the abort lands.
    for (int i = 0; i < T1 + 20; i++) begin
      @(negedge clk);
      n++;
      if (timeout1 === 1'b1) break;
    end
    checks++; if (n != T1 + 2) begin errors++; $display("FAIL timeout_latency got=%0d want=%0d", n, T1 + 2); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL timeout_idle got busy=%b want 0", busy1); end
    repeat (5) @(negedge clk);
    checks++; if (timeout1 !== 1'b1) begin errors++; $display("FAIL timeout_hold got=%b want=1", timeout1); end
    hang = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (timeout1 !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b want=1", timeout1); end
  endtask

  task automatic test_reset_mid();
    bit got = 0;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (timeout1 !== 1'b0) begin errors++; $display("FAIL reset_clears_timeout got=%b want=0", timeout1); end
    push(16'h1E00, 2'b00);
    push(16'h0C0E, 2'b00);
    push(16'h080A, 2'b00);
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin got = 1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL mid_first_loads got left=%0d want=0", exp_q.size()); end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (gen_load1 !== 1'b0)  begin errors++; $display("FAIL mid_reset_load got=%b want=0", gen_load1); end
    checks++; if (init_done1 !== 1'b0) begin errors++; $display("FAIL mid_reset_init_done got=%b want=0", init_done1); end
    push_init();
    reset = 1'b0;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (init_done1 === 1'b1) begin got = 1; break; end
    end
    checks++; if (!got || exp_q.size() != 0) begin errors++; $display("FAIL mid_replay got done=%b left=%0d want 1 and 0", init_done1, exp_q.size()); end
  endtask

  task automatic test_rr4();
    bit got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (init_done4 === 1'b1) begin got = 1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL rr4_init got=0 want=1"); end
    req_data4 = {16'h0300, 16'h0000, 16'h0000, 16'h0100};
    req4 = 4'b0001;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack4 !== 4'b0000) begin got = 1; break; end
    end
    checks++; if (!got || ack4 !== 4'b0001) begin errors++; $display("FAIL rr4_first got=%b want=0001", ack4); end
    req4 = 4'b1001;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack4 !== 4'b0000) begin got = 1; break; end
    end
    checks++; if (!got || ack4 !== 4'b1000 || gen_data4 !== 16'h0300) begin
      errors++; $display("FAIL rr4_second got ack=%b data=%h want 1000 0300", ack4, gen_data4);
    end
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack4 !== 4'b0000) begin got = 1; break; end
    end
    checks++; if (!got || ack4 !== 4'b0001 || gen_data4 !== 16'h0100) begin
      errors++; $display("FAIL rr4_third got ack=%b data=%h want 0001 0100", ack4, gen_data4);
    end
    req4 = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_init();
    test_req_hold();
    test_alternate();
    test_timeout();
    test_reset_mid();
    test_rr4();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit got=expired want=finish");
    $fatal(1, "time limit");
  end
endmodule
